// File: rtl/uart_pkg.sv
// Shared types and register map for the UART receive peripheral.
package uart_pkg;

  // Receiver deframing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Register byte offsets on the IO read port.
  localparam logic [3:0] UART_RX_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_RX_STATUS_OFS = 4'h4;

  // STATUS register bit positions.
  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_FRAME_ERR_BIT = 2;
  localparam int STAT_OVERRUN_BIT   = 3;
  localparam int STAT_COUNT_LSB     = 4;

  // Assemble the low byte of the STATUS register.
  function automatic logic [7:0] pack_status(input logic [3:0] count,
                                             input logic       overrun,
                                             input logic       frame_err,
                                             input logic       full,
                                             input logic       not_empty);
    logic [7:0] s;
    s                          = '0;
    s[STAT_NOT_EMPTY_BIT]      = not_empty;
    s[STAT_FULL_BIT]           = full;
    s[STAT_FRAME_ERR_BIT]      = frame_err;
    s[STAT_OVERRUN_BIT]        = overrun;
    s[STAT_COUNT_LSB +: 4]     = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue peek. A push while full is ignored
// unless a pop in the same cycle frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_peripheral.sv
// Oversampling 8N1 UART receiver with receive FIFO and a registered
// DATA/STATUS read port.
module uart_rx_peripheral
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 108,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        resetActiveHigh,
  input  logic        uartReceive,
  input  logic        readValid,
  input  logic [3:0]  readAddress,
  output logic [31:0] readData,
  output logic        readDataValid,
  output logic        rxInterrupt
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam int             FCW      = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]     sync_q;
  logic           rx_sync;
  rx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_push;
  logic           frame_err_set;

  logic           fifo_pop;
  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           overrun_set;
  logic           overrun_q;
  logic           frame_err_q;
  logic           rd_data;
  logic           rd_status;
  logic [31:0]    read_word;

  assign rx_sync = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) sync_q <= 2'b11;
    else                 sync_q <= {sync_q[0], uartReceive};
  end

  // Deframer state, baud counter, bit index and shift register.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: sample mid-bit, collect LSB-first, validate the stop bit.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_sync;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_sync) begin
            rx_push = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data     = readValid && (readAddress == UART_RX_DATA_OFS);
  assign rd_status   = readValid && (readAddress == UART_RX_STATUS_OFS);
  assign fifo_pop    = rd_data && !fifo_empty;
  assign overrun_set = rx_push && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (resetActiveHigh),
    .push      (rx_push),
    .push_data (shift_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky error flags: a STATUS read clears them, a same-cycle new error wins.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (overrun_set)    overrun_q   <= 1'b1;
      else if (rd_status) overrun_q   <= 1'b0;
      if (frame_err_set)  frame_err_q <= 1'b1;
      else if (rd_status) frame_err_q <= 1'b0;
    end
  end

  // Read mux, evaluated on pre-read state so STATUS reports flags before clearing.
  always_comb begin
    read_word = '0;
    case (readAddress)
      UART_RX_DATA_OFS:   read_word = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      UART_RX_STATUS_OFS: read_word = {24'd0, pack_status(4'(fifo_count), overrun_q,
                                                          frame_err_q, fifo_full, !fifo_empty)};
      default:            read_word = '0;
    endcase
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) begin
      readData      <= '0;
      readDataValid <= 1'b0;
    end else begin
      readDataValid <= readValid;
      if (readValid) readData <= read_word;
    end
  end

  assign rxInterrupt = !fifo_empty || overrun_q || frame_err_q;

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Directed plus randomized bench for uart_rx_peripheral against a queue-based
// model of the receive FIFO and error flags.
module tb_uart_rx_peripheral;
  import uart_pkg::*;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // Edge index of the stop-bit sample, counted from the first edge that
  // registers the start bit: two synchroniser flops, one edge to leave IDLE,
  // half a bit to the start check, then nine bit times.
  localparam int STOP_SAMPLE = 3 + (CPB - 1) / 2 + 9 * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_line;
  logic        read_valid;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  logic        m_ovr;
  logic        m_fe;

  uart_rx_peripheral #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock           (clock),
    .resetActiveHigh (reset),
    .uartReceive     (rx_line),
    .readValid       (read_valid),
    .readAddress     (read_addr),
    .readData        (read_data),
    .readDataValid   (read_data_valid),
    .rxInterrupt     (rx_irq)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_status();
    return {24'd0, 4'(q.size()), m_ovr, m_fe, (q.size() == DEPTH), (q.size() != 0)};
  endfunction

  function automatic logic [31:0] model_status_read();
    logic [31:0] s;
    s     = model_status();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] model_pop();
    if (q.size() == 0) return 32'd0;
    return {24'd0, q.pop_front()};
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)               m_fe = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else                        q.push_back(b);
  endfunction

  function automatic logic model_irq();
    return (q.size() != 0) || m_ovr || m_fe;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input logic [3:0] addr, input string tag);
    logic [31:0] exp;
    if (addr == UART_RX_DATA_OFS)        exp = model_pop();
    else if (addr == UART_RX_STATUS_OFS) exp = model_status_read();
    else                                 exp = 32'd0;
    @(negedge clock);
    read_valid = 1'b1;
    read_addr  = addr;
    @(negedge clock);
    read_valid = 1'b0;
    check({tag, "_dv"}, 32'(read_data_valid), 32'd1);
    check(tag, read_data, exp);
    check({tag, "_irq"}, 32'(rx_irq), 32'(model_irq()));
  endtask

  // Drive one frame starting at the next negedge; optionally strobe a DATA
  // read so it is registered on edge read_at and capture its result.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int stop_cycles,
                            input int read_at, output logic [31:0] cap);
    int len;
    int k;
    len = 9 * CPB + stop_cycles;
    cap = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clock);
      if (c - 1 == read_at) cap = read_data;
      k = c / CPB;
      if (k == 0)      rx_line = 1'b0;
      else if (k <= 8) rx_line = b[k-1];
      else             rx_line = stop_ok;
      read_valid = (c == read_at);
      read_addr  = UART_RX_DATA_OFS;
    end
    @(negedge clock);
    if (len - 1 == read_at) cap = read_data;
    rx_line    = 1'b1;
    read_valid = 1'b0;
    repeat (CPB) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] cap;
    logic [31:0] exp;
    logic [31:0] exp_list[4];
    logic [7:0]  b;

    reset      = 1'b1;
    rx_line    = 1'b1;
    read_valid = 1'b0;
    read_addr  = '0;
    m_ovr      = 1'b0;
    m_fe       = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data", read_data, 32'd0);
    check("rst_dv", 32'(read_data_valid), 32'd0);
    check("rst_irq", 32'(rx_irq), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: single good byte
    send_frame(8'hA5, 1'b1, CPB, -1, cap);
    model_rx(8'hA5, 1'b1);
    check("t1_irq_up", 32'(rx_irq), 32'd1);
    read_check(UART_RX_STATUS_OFS, "t1_status");
    read_check(UART_RX_DATA_OFS, "t1_data");
    read_check(UART_RX_STATUS_OFS, "t1_status2");
    @(negedge clock);
    check("t1_hold", read_data, 32'd0);
    check("t1_dv_idle", 32'(read_data_valid), 32'd0);

    // 2: two-cycle low glitch is rejected at the start-bit check
    @(negedge clock);
    rx_line = 1'b0;
    repeat (2) @(negedge clock);
    rx_line = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    read_check(UART_RX_STATUS_OFS, "t2_status");

    // 3: stop bit held low for 20 bit times
    send_frame(8'h3C, 1'b0, 20 * CPB, -1, cap);
    model_rx(8'h3C, 1'b0);
    read_check(UART_RX_STATUS_OFS, "t3_status");
    read_check(UART_RX_STATUS_OFS, "t3_status2");

    // 4: overflow the FIFO, then drain with back-to-back reads
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, CPB, -1, cap);
      model_rx(8'(i), 1'b1);
    end
    read_check(UART_RX_STATUS_OFS, "t4_status");
    read_check(4'h8, "t4_bad_ofs");
    for (int k = 0; k < 4; k++) exp_list[k] = model_pop();
    @(negedge clock);
    read_valid = 1'b1;
    read_addr  = UART_RX_DATA_OFS;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 3) read_valid = 1'b0;
      check("t4_b2b_data", read_data, exp_list[k]);
    end
    read_check(UART_RX_DATA_OFS, "t4_empty");

    // 5: pop on the stop-sample edge while full makes room for the new byte
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, CPB, -1, cap);
      model_rx(b, 1'b1);
    end
    send_frame(8'h77, 1'b1, CPB, STOP_SAMPLE, cap);
    exp = model_pop();
    model_rx(8'h77, 1'b1);
    check("t5_pop", cap, exp);
    read_check(UART_RX_STATUS_OFS, "t5_status");
    for (int i = 0; i < DEPTH; i++) read_check(UART_RX_DATA_OFS, "t5_data");

    // randomized bytes with random reads
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, CPB, -1, cap);
      model_rx(b, 1'b1);
      case ($urandom_range(0, 2))
        0:       read_check(UART_RX_STATUS_OFS, "rnd_status");
        1:       read_check(UART_RX_DATA_OFS, "rnd_data");
        default: check("rnd_irq", 32'(rx_irq), 32'(model_irq()));
      endcase
    end

    // 6: reset mid-frame during data bit 3 of 0x55
    for (int c = 0; c < 4 * CPB + 3; c++) begin
      @(negedge clock);
      if (c / CPB == 0) rx_line = 1'b0;
      else              rx_line = cap[0] ^ cap[0] ^ 1'(8'h55 >> (c / CPB - 1));
    end
    @(negedge clock);
    reset      = 1'b1;
    rx_line    = 1'b1;
    read_valid = 1'b1;
    read_addr  = UART_RX_STATUS_OFS;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t6_rst_dv", 32'(read_data_valid), 32'd0);
      check("t6_rst_data", read_data, 32'd0);
    end
    reset      = 1'b0;
    read_valid = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    repeat (4) @(negedge clock);
    check("t6_irq", 32'(rx_irq), 32'd0);
    send_frame(8'h99, 1'b1, CPB, -1, cap);
    model_rx(8'h99, 1'b1);
    read_check(UART_RX_STATUS_OFS, "t6_status");
    read_check(UART_RX_DATA_OFS, "t6_data");
    read_check(UART_RX_STATUS_OFS, "t6_status2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
